// File: rtl/trig_detect.sv
// trig_detect: level/edge trigger detector with auto, normal and single modes plus a crossing-period meter.
// Build option: define TRIG_HYST_EN to apply HYST codes of hysteresis to the prep thresholds.
module trig_detect #(
  parameter int unsigned AUTO_TIMEOUT = 2000000,
  parameter int unsigned HYST         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_valid,
  input  logic [7:0]  ad_data_a,
  input  logic [7:0]  ad_data_b,
  input  logic        trig_ch,
  input  logic [7:0]  trig_level,
  input  logic        trig_edge,
  input  logic [1:0]  trig_mode,
  input  logic        arm,
  output logic        trig,
  output logic        trig_forced,
  output logic        armed,
  output logic [23:0] period,
  output logic        period_valid
);

`ifdef TRIG_HYST_EN
  localparam logic [9:0] H_W = 10'(HYST);
`else
  // Hysteresis disabled: HYST stays in the parameter list for drop-in compatibility.
  localparam logic [9:0] H_W = 10'(HYST * 0);
`endif
  localparam logic [20:0] TMO_LAST = 21'(AUTO_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PREP, READY, DONE} state_t;
  state_t state, state_nx;

  logic [7:0]  s, lo, hi, level_q;
  logic [9:0]  lvl_w, sum_w;
  logic        ch_q, edge_q;
  logic        param_chg, ch_chg, prep_cond, fire_cond, in_arm, fire_hit, tmo_fire;
  logic        trig_d, forced_d, armed_d;
  logic [20:0] tmo_cnt;
  logic        pm_ready, pm_first, pm_cross;
  logic [23:0] pm_cnt;

  assign s     = trig_ch ? ad_data_b : ad_data_a;
  assign lvl_w = {2'b00, trig_level};
  assign sum_w = lvl_w + H_W;
  assign lo    = (lvl_w < H_W) ? '0 : 8'(lvl_w - H_W);
  assign hi    = (sum_w > 10'd255) ? '1 : sum_w[7:0];

  assign prep_cond = trig_edge ? (s > hi) : (s < lo);
  assign fire_cond = trig_edge ? (s <= trig_level) : (s >= trig_level);
  assign ch_chg    = (trig_ch != ch_q);
  assign param_chg = ch_chg || (trig_edge != edge_q) || (trig_level != level_q);
  assign in_arm    = (state == PREP) || (state == READY);
  // A parameter change suppresses a coincident fire; a real fire beats a coincident timeout.
  assign fire_hit  = (state == READY) && din_valid && fire_cond && !param_chg;
  assign tmo_fire  = in_arm && (trig_mode == 2'd0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      trig        <= 1'b0;
      trig_forced <= 1'b0;
      armed       <= 1'b0;
      ch_q        <= 1'b0;
      edge_q      <= 1'b0;
      level_q     <= '0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_nx;
      trig        <= trig_d;
      trig_forced <= forced_d;
      armed       <= armed_d;
      ch_q        <= trig_ch;
      edge_q      <= trig_edge;
      level_q     <= trig_level;
      if (arm && (state != DONE))
        tmo_cnt <= '0;
      else if (in_arm && (trig_mode == 2'd0))
        tmo_cnt <= tmo_cnt + 21'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (arm) state_nx = PREP;
      PREP, READY: begin
        if (fire_hit)
          state_nx = (trig_mode == 2'd2) ? DONE : IDLE;
        else if (tmo_fire)
          state_nx = IDLE;
        else if (param_chg)
          state_nx = PREP;
        else if ((state == PREP) && din_valid && prep_cond)
          state_nx = READY;
      end
      DONE: if (trig_mode != 2'd2) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    trig_d   = fire_hit || tmo_fire;
    forced_d = tmo_fire && !fire_hit;
    armed_d  = (state_nx == PREP) || (state_nx == READY);
  end

  // Period meter: free-running rising-edge tracker, independent of the arm state.
  assign pm_cross = din_valid && pm_ready && !ch_chg && (s >= trig_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_ready     <= 1'b0;
      pm_first     <= 1'b1;
      pm_cnt       <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (pm_cnt != '1)
        pm_cnt <= pm_cnt + 24'd1;
      if (ch_chg) begin
        pm_ready <= 1'b0;
        pm_first <= 1'b1;
      end else if (pm_cross) begin
        pm_ready <= 1'b0;
        pm_first <= 1'b0;
        pm_cnt   <= 24'd1;
        if (!pm_first) begin
          period       <= pm_cnt;
          period_valid <= 1'b1;
        end
      end else if (din_valid && (s < lo)) begin
        pm_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trig_detect.sv
// Self-checking bench for trig_detect: directed scenarios plus randomized sequences against a behavioural model.
module tb_trig_detect;
  localparam int unsigned TMO = 16;
`ifdef TRIG_HYST_EN
  localparam int HB = 4;
`else
  localparam int HB = 0;
`endif

  logic        clk = 1'b0, rst_n = 1'b1, din_valid = 1'b0, trig_ch = 1'b0, trig_edge = 1'b0, arm = 1'b0;
  logic [7:0]  ad_data_a = '0, ad_data_b = '0, trig_level = 8'd128;
  logic [1:0]  trig_mode = 2'd1;
  logic        trig, trig_forced, armed, period_valid;
  logic [23:0] period;

  int checks = 0, errors = 0;
  int cyc = 0;
  int trig_q[$];
  bit forced_q[$];
  int pv_cyc_q[$];
  int pv_val_q[$];
  int armed_rise = -1;
  logic armed_prev = 1'b0;
  bit mv[64];
  int ms[64];
  int cyc_of[64];

  trig_detect #(.AUTO_TIMEOUT(TMO), .HYST(4)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .ad_data_a(ad_data_a), .ad_data_b(ad_data_b),
    .trig_ch(trig_ch), .trig_level(trig_level), .trig_edge(trig_edge), .trig_mode(trig_mode), .arm(arm),
    .trig(trig), .trig_forced(trig_forced), .armed(armed), .period(period), .period_valid(period_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (trig === 1'b1) begin trig_q.push_back(cyc); forced_q.push_back(trig_forced); end
      if (period_valid === 1'b1) begin pv_cyc_q.push_back(cyc); pv_val_q.push_back(int'(period)); end
      if (armed === 1'b1 && armed_prev !== 1'b1) armed_rise = cyc;
    end
    armed_prev = armed;
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic put(input bit v, input logic [7:0] sv);
    tick(); arm = 1'b0; din_valid = v;
    if (trig_ch) begin ad_data_b = sv; ad_data_a = 8'($urandom); end
    else begin ad_data_a = sv; ad_data_b = 8'($urandom); end
  endtask

  task automatic do_arm(); tick(); arm = 1'b1; din_valid = 1'b0; endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin tick(); arm = 1'b0; din_valid = 1'b0; end
  endtask

  task automatic clear_logs();
    trig_q.delete(); forced_q.delete(); pv_cyc_q.delete(); pv_val_q.delete(); armed_rise = -1;
  endtask

  // Reference: index of the first valid sample that fires after a valid prep sample, or -1.
  function automatic int ref_fire(input int n, input bit edg, input int lvl);
    int lo = (lvl - HB < 0) ? 0 : lvl - HB;
    int hi = (lvl + HB > 255) ? 255 : lvl + HB;
    bit prepped = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (mv[i]) begin
        if (!prepped) prepped = edg ? (ms[i] > hi) : (ms[i] < lo);
        else if (edg ? (ms[i] <= lvl) : (ms[i] >= lvl)) return i;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({trig, trig_forced, armed, period_valid} !== 4'b0 || period !== 24'd0) begin
      errors++;
      $display("FAIL reset: trig=%b forced=%b armed=%b pv=%b period=%0d, required all 0",
               trig, trig_forced, armed, period_valid, period);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_rising();
    int c;
    trig_ch = 0; trig_edge = 0; trig_level = 128; trig_mode = 1;
    idle(2); clear_logs();
    do_arm(); put(1, 100); put(1, 126); put(1, 130); c = cyc;
    idle(1);
    checks++;
    if (trig !== 1'b1 || armed !== 1'b0) begin
      errors++; $display("FAIL rising_strobe: trig=%b armed=%b, required trig=1 armed=0", trig, armed);
    end
    idle(2);
    checks++;
    if (trig_q.size() != 1 || trig_q[0] != c + 1 || forced_q[0] != 1'b0) begin
      errors++; $display("FAIL rising_timing: %0d trigs first@%0d, required 1 trig @%0d forced 0",
                         trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, c + 1);
    end
    clear_logs();
    put(1, 100); put(1, 110); put(1, 120); put(1, 130); idle(3);
    checks++;
    if (trig_q.size() != 0 || armed !== 1'b0) begin
      errors++; $display("FAIL rising_no_rearm: %0d trigs armed=%b, required 0 trigs armed=0", trig_q.size(), armed);
    end
  endtask

  task automatic test_falling();
    int c;
    trig_ch = 1; trig_edge = 1; trig_level = 128; trig_mode = 1;
    idle(2); clear_logs();
    do_arm(); put(1, 200); put(1, 129); put(1, 128); c = cyc; idle(3);
    checks++;
    if (trig_q.size() != 1 || trig_q[0] != c + 1 || forced_q[0] != 1'b0) begin
      errors++; $display("FAIL falling: %0d trigs first@%0d, required 1 trig @%0d forced 0",
                         trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, c + 1);
    end
  endtask

  task automatic test_auto();
    trig_ch = 0; trig_edge = 0; trig_level = 128; trig_mode = 0;
    idle(2); clear_logs();
    do_arm();
    for (int i = 0; i < 40 && trig_q.size() == 0; i++) put(1, 50);
    idle(1);
    checks++;
    if (trig_q.size() == 0) begin
      errors++; $display("FAIL auto_timeout: no trig within 40 cycles, required trig at armed+%0d", TMO);
    end else if (armed_rise < 0 || trig_q[0] != armed_rise + int'(TMO) || forced_q[0] != 1'b1) begin
      errors++; $display("FAIL auto_timeout: trig@%0d forced=%b, required @%0d forced 1",
                         trig_q[0], forced_q[0], armed_rise + int'(TMO));
    end
  endtask

  task automatic test_fire_timeout();
    int n;
    trig_ch = 0; trig_edge = 0; trig_level = 128; trig_mode = 0;
    idle(2); clear_logs();
    do_arm(); n = cyc;
    put(1, 50);
    while (cyc < n + 15) put(0, 200);
    put(1, 200);
    idle(3);
    checks++;
    if (trig_q.size() != 1 || trig_q[0] != n + 17 || forced_q[0] != 1'b0) begin
      errors++; $display("FAIL fire_vs_timeout: %0d trigs first@%0d, required 1 trig @%0d forced 0",
                         trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, n + 17);
    end
  endtask

  task automatic test_single();
    int c;
    trig_ch = 0; trig_edge = 0; trig_level = 128; trig_mode = 2;
    idle(2); clear_logs();
    do_arm(); put(1, 100); put(1, 130); c = cyc; idle(3);
    do_arm(); put(1, 100); put(1, 130); idle(3);
    checks++;
    if (trig_q.size() != 1 || trig_q[0] != c + 1 || armed !== 1'b0) begin
      errors++; $display("FAIL single_once: %0d trigs armed=%b, required 1 trig @%0d armed 0",
                         trig_q.size(), armed, c + 1);
    end
    trig_mode = 1; idle(2); clear_logs();
    do_arm(); put(1, 100); put(1, 130); c = cyc; idle(3);
    checks++;
    if (trig_q.size() != 1 || trig_q[0] != c + 1) begin
      errors++; $display("FAIL single_exit: %0d trigs, required 1 trig @%0d", trig_q.size(), c + 1);
    end
  endtask

  task automatic test_hyst();
    int c;
    int exp_n = (HB > 0) ? 0 : 1;
    trig_ch = 0; trig_edge = 0; trig_level = 128; trig_mode = 1;
    idle(2); clear_logs();
    do_arm();
    for (int i = 0; i < 4; i++) begin put(1, 125); put(1, 129); end
    idle(2);
    checks++;
    if (trig_q.size() != exp_n) begin
      errors++; $display("FAIL hyst_toggle: %0d trigs, required %0d", trig_q.size(), exp_n);
    end
    do_arm(); put(1, 123); put(1, 129); c = cyc; idle(3);
    checks++;
    if (trig_q.size() != exp_n + 1 || trig_q[trig_q.size() - 1] != c + 1) begin
      errors++; $display("FAIL hyst_dip: %0d trigs, required %0d with last @%0d", trig_q.size(), exp_n + 1, c + 1);
    end
  endtask

  task automatic test_param_change();
    int c;
    trig_ch = 0; trig_edge = 0; trig_level = 128; trig_mode = 1;
    idle(2); clear_logs();
    do_arm(); put(1, 100); put(1, 130); trig_level = 127;
    put(0, 0); put(0, 0);
    checks++;
    if (trig_q.size() != 0) begin
      errors++; $display("FAIL param_change_fire: %0d trigs, required 0", trig_q.size());
    end
    put(1, 100); put(1, 130); c = cyc; idle(3);
    checks++;
    if (trig_q.size() != 1 || trig_q[0] != c + 1) begin
      errors++; $display("FAIL param_change_reprep: %0d trigs, required 1 trig @%0d", trig_q.size(), c + 1);
    end
    trig_level = 128;
  endtask

  task automatic test_arm_fire();
    int c;
    trig_ch = 0; trig_edge = 0; trig_level = 128; trig_mode = 1;
    idle(2); clear_logs();
    do_arm(); put(1, 100); put(1, 130); arm = 1'b1; c = cyc;
    idle(3);
    checks++;
    if (trig_q.size() != 1 || trig_q[0] != c + 1 || armed !== 1'b0) begin
      errors++; $display("FAIL arm_with_fire: %0d trigs armed=%b, required 1 trig @%0d armed 0",
                         trig_q.size(), armed, c + 1);
    end
  endtask

  task automatic test_unreachable();
    int n;
    trig_ch = 0; trig_edge = 0; trig_level = 0; trig_mode = 1;
    idle(2); clear_logs();
    do_arm();
    for (int i = 0; i < 20; i++) put(1, 8'($urandom));
    idle(2);
    checks++;
    if (trig_q.size() != 0 || armed !== 1'b1) begin
      errors++; $display("FAIL unreachable_normal: %0d trigs armed=%b, required 0 trigs armed 1", trig_q.size(), armed);
    end
    trig_mode = 0;
    do_arm(); n = cyc;
    for (int i = 0; i < 40 && trig_q.size() == 0; i++) put(1, 8'($urandom));
    idle(1);
    checks++;
    if (trig_q.size() != 1 || trig_q[0] != n + 17 || forced_q[0] != 1'b1) begin
      errors++; $display("FAIL unreachable_auto: %0d trigs first@%0d, required 1 forced trig @%0d",
                         trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, n + 17);
    end
    trig_level = 128;
  endtask

  task automatic test_random_trig();
    for (int it = 0; it < 8; it++) begin
      bit edg = 1'($urandom_range(0, 1));
      int lvl = $urandom_range(10, 245);
      int e;
      trig_mode = 1;
      trig_level = 8'(lvl ^ 1); idle(1);
      trig_edge = edg; trig_level = 8'(lvl); trig_ch = 1'($urandom_range(0, 1));
      idle(2); clear_logs();
      do_arm();
      for (int i = 0; i < 32; i++) begin
        mv[i] = 1'($urandom_range(0, 1));
        ms[i] = $urandom_range(0, 255);
        put(mv[i], 8'(ms[i]));
        cyc_of[i] = cyc;
      end
      idle(3);
      e = ref_fire(32, edg, lvl);
      checks++;
      if (e < 0) begin
        if (trig_q.size() != 0) begin
          errors++; $display("FAIL random_trig it%0d: %0d trigs, required 0", it, trig_q.size());
        end
      end else if (trig_q.size() != 1 || trig_q[0] != cyc_of[e] + 1 || forced_q[0] != 1'b0) begin
        errors++; $display("FAIL random_trig it%0d: %0d trigs first@%0d, required 1 trig @%0d",
                           it, trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, cyc_of[e] + 1);
      end
    end
  endtask

  task automatic test_period();
    int cr[3];
    int ca, cb;
    trig_mode = 1; trig_ch = 0; trig_edge = 0; trig_level = 128;
    tick(); rst_n = 1'b0; tick(); rst_n = 1'b1; clear_logs();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 500; i++) put(1, 0);
      for (int i = 0; i < 500; i++) begin put(1, 255); if (i == 0) cr[p] = cyc; end
    end
    put(1, 0); idle(2);
    checks++;
    if (pv_cyc_q.size() != 2) begin
      errors++; $display("FAIL period_count: %0d strobes, required 2", pv_cyc_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pv_val_q[k] != 1000 || pv_cyc_q[k] != cr[k + 1] + 1) begin
          errors++; $display("FAIL period_value[%0d]: %0d @%0d, required 1000 @%0d",
                             k, pv_val_q[k], pv_cyc_q[k], cr[k + 1] + 1);
        end
      end
    end
    for (int i = 0; i < 500; i++) put(1, 0);
    for (int i = 0; i < 200; i++) put(1, 255);
    rst_n = 1'b0; #1;
    checks++;
    if ({trig, trig_forced, armed, period_valid} !== 4'b0 || period !== 24'd0) begin
      errors++; $display("FAIL midrun_reset: trig=%b forced=%b armed=%b pv=%b period=%0d, required all 0",
                         trig, trig_forced, armed, period_valid, period);
    end
    tick(); tick();
    rst_n = 1'b1; clear_logs();
    for (int i = 0; i < 300; i++) put(1, 255);
    for (int i = 0; i < 500; i++) put(1, 0);
    for (int i = 0; i < 500; i++) begin put(1, 255); if (i == 0) ca = cyc; end
    for (int i = 0; i < 500; i++) put(1, 0);
    for (int i = 0; i < 500; i++) begin put(1, 255); if (i == 0) cb = cyc; end
    put(1, 0); idle(2);
    checks++;
    if (pv_cyc_q.size() != 1 || pv_val_q[0] != cb - ca || pv_cyc_q[0] != cb + 1) begin
      errors++; $display("FAIL period_after_reset: %0d strobes, required 1 strobe of 1000 @%0d",
                         pv_cyc_q.size(), cb + 1);
    end
  endtask

  task automatic test_random_period();
    int cr[8];
    trig_mode = 1; trig_edge = 0; trig_level = 128; trig_ch = 1'($urandom_range(0, 1));
    tick(); rst_n = 1'b0; tick(); rst_n = 1'b1; clear_logs();
    for (int p = 0; p < 8; p++) begin
      int nl = $urandom_range(3, 40);
      int nh = $urandom_range(3, 40);
      for (int i = 0; i < nl; i++) put(1, 8'($urandom_range(0, 100)));
      for (int i = 0; i < nh; i++) begin
        put(1, 8'($urandom_range(128, 255)));
        if (i == 0) cr[p] = cyc;
      end
    end
    put(1, 0); idle(2);
    checks++;
    if (pv_cyc_q.size() != 7) begin
      errors++; $display("FAIL random_period_count: %0d strobes, required 7", pv_cyc_q.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (pv_val_q[k] != cr[k + 1] - cr[k] || pv_cyc_q[k] != cr[k + 1] + 1) begin
          errors++; $display("FAIL random_period[%0d]: %0d @%0d, required %0d @%0d",
                             k, pv_val_q[k], pv_cyc_q[k], cr[k + 1] - cr[k], cr[k + 1] + 1);
        end
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_auto();
    test_fire_timeout();
    test_single();
    test_hyst();
    test_param_change();
    test_arm_fire();
    test_unreachable();
    test_random_trig();
    test_period();
    test_random_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trig_detect.md
# trig_detect

Edge trigger detector between the averaging filters and the capture buffer controller. It watches the selected filtered ADC channel and issues a one-cycle trigger strobe when the programmed level is crossed on the programmed edge. It supports auto, normal and single modes, and forces a trigger after a timeout in auto mode. It also measures the period between consecutive qualified crossings, which feeds the frequency readout.

## Interface
- AUTO_TIMEOUT, 2000000, clk cycles spent armed in auto mode before a trigger is forced (20 ms at 100 MHz); must be ≥ 2.
- HYST, 4, hysteresis in ADC codes; only used when the hysteresis macro is defined.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; asynchronous assert, active-low.
- din_valid  in  1  the current ad_data_a/ad_data_b pair is a new sample.
- ad_data_a  in  8  filtered channel A sample, unsigned.
- ad_data_b  in  8  filtered channel B sample, unsigned.
- trig_ch  in  1  source channel: 0 = A, 1 = B.
- trig_level  in  8  trigger level, unsigned code.
- trig_edge  in  1  edge select: 0 = rising, 1 = falling.
- trig_mode  in  2  mode: 0 = auto, 1 = normal, 2 = single, 3 = treated as normal.
- arm  in  1  one-cycle re-arm request, issued by the capture controller once the buffer is ready.
- trig  out  1  one-cycle trigger strobe.
- trig_forced  out  1  qualifies trig: high when the trigger was caused by auto timeout.
- armed  out  1  high in PREP and READY.
- period  out  24  clk cycles between the last two qualified crossings.
- period_valid  out  1  one-cycle strobe when period updates.

## Operation
- Source sample s = trig_ch ? ad_data_b : ad_data_a. A sample is evaluated only when din_valid = 1.
- Thresholds: lo = max(trig_level − H, 0) and hi = min(trig_level + H, 255), where H is HYST or 0 (see Configuration).
- Rising edge: prep when s < lo; fire when s ≥ trig_level.
- Falling edge: prep when s > hi; fire when s ≤ trig_level.
- If the prep condition can never be met (rising with lo = 0, or falling with hi = 255), normal mode never triggers and auto mode triggers only on timeout.
- State machine states and transitions:
  - IDLE: entered after reset or after a trigger. arm → PREP.
  - PREP: prep sample → READY.
  - READY: fire sample → trig = 1. Next state is DONE if trig_mode = 2, otherwise IDLE.
  - DONE: arm is ignored. Leaves to IDLE when trig_mode ≠ 2.
- Auto timeout:
  - A 21-bit counter clears on arm and counts every cycle in PREP/READY while trig_mode = 0.
  - When it reaches AUTO_TIMEOUT−1, trig = trig_forced = 1 and the state goes to IDLE.
  - The counter holds in other modes.
- Re-qualification: registered copies of trig_ch, trig_edge and trig_level are compared each cycle. Any change while in PREP/READY returns the state to PREP. The timeout counter is not cleared.
- Period meter:
  - Independent of arm state. It runs its own prep/fire tracker on s, always using rising-edge thresholds.
  - A 24-bit counter increments every clk and restarts at 1 on each qualified crossing.
  - On a crossing, period receives the count (saturated at 24'hFFFFFF) and period_valid pulses.
  - The first crossing after reset or after a trig_ch change only restarts the counter and produces no period_valid.

## Timing
- All outputs are registered. Reset values: trig = 0, trig_forced = 0, armed = 0, period = 0, period_valid = 0, state = IDLE, counters = 0.
- Latency: a fire sample at cycle n gives trig high during cycle n+1 only. Same latency for period_valid.
- arm at cycle n in IDLE gives armed = 1 at n+1. A sample arriving with arm at cycle n is not evaluated.
- Simultaneous events:
  - arm together with a fire sample in READY: the fire wins and arm is dropped.
  - Fire sample and timeout in the same cycle: a real trigger is issued with trig_forced = 0.
  - Parameter change together with a fire sample: the change wins and there is no trig.
- Counter saturation: period holds 24'hFFFFFF if no crossing occurs for 2^24 cycles.
- Reset mid-operation aborts any pending trigger immediately. No strobe is emitted during or after reset.

## Configuration
- TRIG_HYST_EN:
  - Defined: H = HYST, giving noise-immune arming.
  - Undefined: H = 0 and the HYST parameter is ignored, so prep means strictly below the level for rising and strictly above it for falling.

## Test plan
- Rising, level 128, HYST 4, normal mode:
  - arm, then samples 100, 126, 130 → no trig on 126, trig one cycle after 130, armed falls with it.
  - Without a new arm, a second ramp 100→130 → no trig.
- Falling, level 128, samples 200, 129, 128 → trig one cycle after 128 with trig_forced = 0.
- Auto mode, AUTO_TIMEOUT = 16, constant input 50, arm → trig = trig_forced = 1 exactly 16 cycles after armed rises.
- Single mode, two crossings:
  - Two crossings each preceded by arm → exactly one trig; state stays DONE.
  - trig_mode set to 1, then arm → triggers again.
- Hysteresis, TRIG_HYST_EN defined, HYST 4, level 128:
  - Samples toggling 125/129 → no trig.
  - Samples dipping to 123 then 129 → trig.
  - Without the macro, the 125/129 toggling triggers.
- Period meter, square wave 0/255 with a 1000-cycle period (din_valid every cycle):
  - period_valid every 1000 cycles with period = 1000.
  - rst_n pulsed mid-run → all outputs 0 and the first crossing after reset gives no period_valid.
